// File: rtl/audio_framer.sv
// audio_framer: pre-emphasis plus overlapped framing for an MFCC front end.
//
// Every PCM sample strobed in with `write` is pre-emphasized
// (y = x - x_prev + x_prev >>> PE_SHIFT, saturated to 16 bits) and stored in a
// 2*FRAME_LEN circular RAM. A frame of FRAME_LEN samples becomes due when the
// first FRAME_LEN samples have arrived, and then on every HOP-th sample. The
// frame is streamed out with a valid/ready handshake. One further frame may
// queue behind the frame being emitted. A frame that arrives while one is
// already queued is dropped, and the sticky `overrun` flag is set.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-low
//   x_i          signed PCM sample, qualified by write
//   write        one-cycle strobe; x_i is valid this cycle
//   rdy_i        downstream accepts x_o this cycle
//   x_o          signed pre-emphasized frame sample
//   dv_out       x_o / out_index valid
//   out_index    sample position within the frame
//   frame_start  high with index 0 of each frame
//   overrun      sticky; a frame was dropped
module audio_framer #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int PE_SHIFT  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [15:0]           x_i,
  input  logic                         write,
  input  logic                         rdy_i,
  output logic signed [15:0]           x_o,
  output logic                         dv_out,
  output logic [$clog2(FRAME_LEN)-1:0] out_index,
  output logic                         frame_start,
  output logic                         overrun
);

  localparam int DATA_W = 16;
  localparam int EXT_W  = 18;
  localparam int AW     = $clog2(2 * FRAME_LEN);
  localparam int IW     = $clog2(FRAME_LEN);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-32768);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_IDLE = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [EXT_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  state_t                     state_q, state_d;
  logic                       pend_q, pend_d;
  logic [AW-1:0]              pend_base_q, pend_base_d;
  logic                       ovr_q, ovr_d;
  logic [31:0]                cnt_q;
  logic [AW-1:0]              wptr_q;
  logic signed [DATA_W-1:0]   x_prev_q;
  logic                       dv_q;
  logic [IW-1:0]              idx_q;
  logic signed [DATA_W-1:0]   x_o_q;
  logic [AW-1:0]              cur_base_q;

  logic signed [DATA_W-1:0]   y_p0;
  logic [AW-1:0]              waddr_p0;
  logic                       vld_p0;
  logic signed [DATA_W-1:0]   ram [2*FRAME_LEN];

  logic signed [DATA_W-1:0]   y_c;
  logic [31:0]                cnt_inc;
  logic                       due_c;
  logic [AW-1:0]              base_c;
  logic                       acc_c;
  logic                       last_c;
  logic [AW-1:0]              rd_next_c;
  logic                       load_c;
  logic [AW-1:0]              load_base_c;
  logic                       direct_c;
  logic                       consume_c;

  assign y_c = sat16(EXT_W'(x_i) - EXT_W'(x_prev_q) + (EXT_W'(x_prev_q) >>> PE_SHIFT));

  assign cnt_inc = cnt_q + 32'd1;
  // Until the first frame only the fill level matters. After that, frames
  // land on HOP boundaries of the free-running count.
  assign due_c   = write && ((state_q == S_FILL) ? (cnt_inc == 32'(FRAME_LEN))
                                                 : ((cnt_inc % 32'(HOP)) == 32'd0));
  // wptr_q is the slot the completing sample will occupy. The frame ends there.
  assign base_c  = wptr_q - AW'(FRAME_LEN - 1);

  assign acc_c     = dv_q && rdy_i;
  assign last_c    = acc_c && (idx_q == IW'(FRAME_LEN - 1));
  assign rd_next_c = cur_base_q + AW'(idx_q) + AW'(1);

  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    load_base_c = pend_base_q;
    direct_c    = 1'b0;
    consume_c   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (due_c) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pend_q) begin
          state_d   = S_EMIT;
          load_c    = 1'b1;
          consume_c = 1'b1;
        end
      end
      S_EMIT: begin
        if (last_c) begin
          if (pend_q) begin
            load_c    = 1'b1;
            consume_c = 1'b1;
          end else if (due_c) begin
            // A frame completing on the final handshake starts straight away,
            // so dv_out does not drop between the two frames.
            load_c      = 1'b1;
            load_base_c = base_c;
            direct_c    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    ovr_d       = ovr_q;
    if (consume_c) pend_d = 1'b0;
    if (due_c && !direct_c) begin
      // The pending slot frees up on the same edge it is consumed, so a new
      // frame may take it then. Otherwise the new frame is dropped.
      if (pend_q && !consume_c) begin
        ovr_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_base_d = base_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FILL;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      x_prev_q    <= '0;
      vld_p0      <= 1'b0;
      dv_q        <= 1'b0;
      idx_q       <= '0;
      x_o_q       <= '0;
      cur_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
      ovr_q       <= ovr_d;
      vld_p0      <= write;
      if (write) begin
        cnt_q    <= cnt_inc;
        wptr_q   <= wptr_q + AW'(1);
        x_prev_q <= x_i;
      end
      if (load_c) begin
        dv_q       <= 1'b1;
        idx_q      <= '0;
        cur_base_q <= load_base_c;
        x_o_q      <= ram[load_base_c];
      end else if (last_c) begin
        dv_q  <= 1'b0;
        idx_q <= '0;
      end else if (acc_c) begin
        idx_q <= idx_q + IW'(1);
        x_o_q <= ram[rd_next_c];
      end
    end
  end

  // p0 -> RAM: the sample lands in its slot one cycle after its write strobe.
  always_ff @(posedge clk) begin
    if (write) begin
      y_p0     <= y_c;
      waddr_p0 <= wptr_q;
    end
    if (vld_p0) ram[waddr_p0] <= y_p0;
  end

  assign x_o         = x_o_q;
  assign dv_out      = dv_q;
  assign out_index   = idx_q;
  assign frame_start = dv_q && (idx_q == '0);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_audio_framer.sv
// Self-checking bench for audio_framer: a scoreboard of expected frame
// samples is filled as writes are driven and drained as the DUT emits.
`timescale 1ns/1ps
module tb_audio_framer;

  localparam int FL  = 256;
  localparam int HOP = 128;
  localparam int PES = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [15:0] x_i = '0;
  logic              write = 1'b0;
  logic              rdy_i = 1'b1;
  logic signed [15:0] x_o;
  logic              dv_out;
  logic [7:0]        out_index;
  logic              frame_start;
  logic              overrun;

  always #5 clk = ~clk;

  audio_framer #(.FRAME_LEN(FL), .HOP(HOP), .PE_SHIFT(PES)) dut (
    .clk(clk), .reset(reset), .x_i(x_i), .write(write), .rdy_i(rdy_i),
    .x_o(x_o), .dv_out(dv_out), .out_index(out_index),
    .frame_start(frame_start), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int val;
    int idx;
  } exp_t;

  exp_t sbq[$];
  int   yh[$];
  int   m_cnt  = 0;
  int   m_prev = 0;
  bit   m_fill = 1'b1;

  function automatic int pe_model(int x, int p);
    int v;
    v = x - p + (p >>> PES);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic model_reset();
    sbq.delete();
    yh.delete();
    m_cnt  = 0;
    m_prev = 0;
    m_fill = 1'b1;
  endtask

  // Runs just after the edge that accepted the write.
  task automatic model_write(int x);
    int y;
    bit due;
    y = pe_model(x, m_prev);
    m_prev = x;
    yh.push_back(y);
    m_cnt++;
    due = m_fill ? (m_cnt == FL) : ((m_cnt % HOP) == 0);
    if (due) begin
      m_fill = 1'b0;
      // More than one frame's worth outstanding means a frame is already queued.
      if (sbq.size() <= FL) begin
        for (int i = 0; i < FL; i++) begin
          exp_t e;
          e.val = yh[m_cnt - FL + i];
          e.idx = i;
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic do_write(int x);
    x_i   = 16'(x);
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    model_write(x);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    exp_t e;
    logic signed [15:0] ev;
    logic [7:0] ei;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && dv_out === 1'b1 && rdy_i === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got idx=%0d x=%0d, required no output", out_index, x_o);
        end else begin
          e  = sbq.pop_front();
          ev = 16'(e.val);
          ei = 8'(e.idx);
          if (x_o !== ev || out_index !== ei || frame_start !== (e.idx == 0)) begin
            bad++;
            $display("FAIL out_sample: got idx=%0d x=%0d fs=%b, required idx=%0d x=%0d fs=%b",
                     out_index, x_o, frame_start, ei, ev, (e.idx == 0));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write = 1'b1;
    x_i   = 16'sd12345;
    rdy_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (dv_out !== 1'b0)      begin bad++; $display("FAIL rst_dv: got %b required 0", dv_out); end
    total++; if (x_o !== 16'sd0)       begin bad++; $display("FAIL rst_x: got %0d required 0", x_o); end
    total++; if (out_index !== 8'd0)   begin bad++; $display("FAIL rst_idx: got %0d required 0", out_index); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b required 0", frame_start); end
    total++; if (overrun !== 1'b0)     begin bad++; $display("FAIL rst_ovr: got %b required 0", overrun); end
    @(posedge clk); #1;
    write = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_constant();
    bit ok;
    rdy_i = 1'b1;
    for (int n = 0; n < FL - 1; n++) do_write(1000);
    x_i   = 16'sd1000;
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    model_write(1000);
    @(negedge clk);
    total++; if (dv_out !== 1'b0) begin bad++; $display("FAIL lat_early: got dv=%b required 0", dv_out); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (dv_out !== 1'b1 || out_index !== 8'd0 || x_o !== 16'sd1000 || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL lat_first: got dv=%b idx=%0d x=%0d fs=%b required dv=1 idx=0 x=1000 fs=1",
               dv_out, out_index, x_o, frame_start);
    end
    @(posedge clk); #1;
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL const_drain: got %0d left required 0", sbq.size()); end
    @(negedge clk);
    total++; if (dv_out !== 1'b0)  begin bad++; $display("FAIL const_single: got dv=%b required 0", dv_out); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL const_ovr: got %b required 0", overrun); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit ok;
    bit found;
    apply_reset();
    rdy_i = 1'b1;
    do_write(-32768);
    do_write(32767);
    do_write(32767);
    do_write(-32768);
    for (int n = 0; n < FL - 4; n++) do_write(0);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1 && out_index === 8'd1) begin found = 1'b1; break; end
    end
    total++;
    if (!found || x_o !== 16'sh7fff) begin
      bad++; $display("FAIL sat_pos: got found=%b x=%0d required x=32767", found, x_o);
    end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1 && out_index === 8'd3) begin found = 1'b1; break; end
    end
    total++;
    if (!found || x_o !== 16'sh8000) begin
      bad++; $display("FAIL sat_neg: got found=%b x=%0d required x=-32768", found, x_o);
    end
    @(posedge clk); #1;
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_drain: got %0d left required 0", sbq.size()); end
  endtask

  task automatic test_hop();
    bit ok;
    bit second;
    int gaps;
    apply_reset();
    rdy_i = 1'b1;
    for (int n = 0; n < FL + HOP; n++) do_write(n);
    // Frame 1 is mid-emission here. The next frame_start belongs to frame 2.
    second = 1'b0;
    gaps   = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (dv_out !== 1'b1) gaps++;
      if (frame_start === 1'b1) begin second = 1'b1; break; end
    end
    total++;
    if (!second || x_o !== 16'sd4) begin
      bad++; $display("FAIL hop_start: got found=%b x=%0d required x=4", second, x_o);
    end
    total++; if (gaps != 0) begin bad++; $display("FAIL hop_gap: got %0d idle cycles required 0", gaps); end
    @(posedge clk); #1;
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL hop_drain: got %0d left required 0", sbq.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit found;
    logic signed [15:0] held;
    apply_reset();
    rdy_i = 1'b1;
    for (int n = 0; n < FL; n++) do_write(int'($urandom_range(0, 65535)) - 32768);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1 && out_index === 8'd9) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL bp_reach: got no index 9 required index 9"); end
    @(posedge clk); #1;
    rdy_i = 1'b0;
    held  = 16'(yh[10]);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if (dv_out !== 1'b1 || out_index !== 8'd10 || x_o !== held) begin
        bad++;
        $display("FAIL bp_hold: got dv=%b idx=%0d x=%0d required dv=1 idx=10 x=%0d",
                 dv_out, out_index, x_o, held);
      end
    end
    @(posedge clk); #1;
    rdy_i = 1'b1;
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain: got %0d left required 0", sbq.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    logic signed [15:0] first;
    int dv_seen;
    apply_reset();
    rdy_i = 1'b0;
    for (int n = 0; n < FL + HOP; n++) do_write(3 * n - 500);
    @(negedge clk);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b required 0", overrun); end
    @(posedge clk); #1;
    for (int n = FL + HOP; n < 2 * FL; n++) do_write(3 * n - 500);
    @(negedge clk);
    first = 16'(yh[0]);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b required 1", overrun); end
    total++;
    if (dv_out !== 1'b1 || out_index !== 8'd0 || x_o !== first) begin
      bad++;
      $display("FAIL ovr_stall: got dv=%b idx=%0d x=%0d required dv=1 idx=0 x=%0d",
               dv_out, out_index, x_o, first);
    end
    @(posedge clk); #1;
    rdy_i = 1'b1;
    wait_drain(700, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_drain: got %0d left required 0", sbq.size()); end
    dv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1) dv_seen++;
    end
    total++; if (dv_seen != 0) begin bad++; $display("FAIL ovr_dropped: got %0d extra cycles required 0", dv_seen); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int dv_seen;
    apply_reset();
    rdy_i = 1'b1;
    for (int n = 0; n < FL; n++) do_write(1000 + n);
    found = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1 && out_index === 8'd99) begin found = 1'b1; break; end
    end
    @(posedge clk); #1;
    total++;
    if (!found || out_index !== 8'd100) begin
      bad++; $display("FAIL rmid_reach: got idx=%0d required 100", out_index);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (dv_out !== 1'b0 || out_index !== 8'd0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear: got dv=%b idx=%0d ovr=%b required dv=0 idx=0 ovr=0",
               dv_out, out_index, overrun);
    end
    @(posedge clk); #1;
    for (int n = 0; n < FL - 1; n++) do_write(-7 * n);
    dv_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dv_out === 1'b1) dv_seen++;
    end
    total++; if (dv_seen != 0) begin bad++; $display("FAIL rmid_refill: got %0d early cycles required 0", dv_seen); end
    @(posedge clk); #1;
    do_write(-7 * (FL - 1));
    wait_drain(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_drain: got %0d left required 0", sbq.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    test_reset();
    test_constant();
    test_saturation();
    test_hop();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_framer.md
AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 The block SHALL have these parameters:
- FRAME_LEN, 256, samples per frame.
- HOP, 128, new samples between frame starts.
- PE_SHIFT, 5, pre-emphasis coefficient 1 - 2^-PE_SHIFT.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-low.
- x_i, in, 16, signed PCM sample.
- write, in, 1, one-cycle strobe; x_i is valid this cycle.
- rdy_i, in, 1, downstream (MFCC) accepts x_o this cycle.
- x_o, out, 16, signed pre-emphasized frame sample.
- dv_out, out, 1, x_o/out_index valid.
- out_index, out, log2(FRAME_LEN), sample position within frame.
- frame_start, out, 1, high with index 0 of each frame.
- overrun, out, 1, sticky; a frame was dropped.

Function
REQ-003 Pre-emphasis SHALL be computed per write as y = x_i - x_prev + (x_prev >>> PE_SHIFT).
- Evaluated in 18-bit signed.
- Saturated to [-32768, 32767].
- x_prev then updated to x_i.
REQ-004 y SHALL be written to a 2*FRAME_LEN circular sample RAM one cycle after write, at the write pointer; the pointer wraps modulo 2*FRAME_LEN.
REQ-005 Every write cycle SHALL be accepted, including consecutive-cycle writes and writes during emission; no write is ever ignored.
REQ-006 A sample counter SHALL track accepted samples. A frame becomes due:
- on the write completing the first FRAME_LEN samples after reset;
- thereafter on every HOP-th write.
REQ-007 The state machine SHALL have three states:
- FILL: reset state; goes to IDLE when the first frame is due.
- IDLE: goes to EMIT the cycle after a frame becomes due, or immediately if pending=1.
- EMIT: goes to IDLE (or re-enters EMIT if pending=1) after index FRAME_LEN-1 is accepted.
REQ-008 At frame due time, the frame base SHALL be latched as the write address minus FRAME_LEN + 1 (mod 2*FRAME_LEN), i.e. the oldest FRAME_LEN samples ending with the completing sample.
REQ-009 In EMIT, output SHALL be registered:
- dv_out=1;
- x_o = RAM[base + out_index];
- out_index increments by 1 only on cycles where dv_out & rdy_i.
REQ-010 When rdy_i=0, x_o, out_index and dv_out SHALL hold their values unchanged.
REQ-011 frame_start SHALL equal dv_out & (out_index==0).
REQ-012 Minimum frame latency SHALL be: first dv_out two cycles after the completing write, given rdy_i=1 and no emission in progress.
REQ-013 A frame becoming due during EMIT SHALL set pending=1 and latch its base; emission of it starts the cycle after the current frame completes, with dv_out continuous across the boundary.
REQ-014 If a frame becomes due while pending=1, that frame SHALL be dropped, overrun SHALL set to 1 and stay set until reset, and the pending base SHALL be unchanged.
REQ-015 A write coinciding with the last accepted index of a frame SHALL be accepted normally, and any due frame it creates SHALL follow per REQ-013.
REQ-016 The counter SHALL be 32-bit and wrap silently; frame due detection SHALL use the count modulo HOP after FILL.

Reset
REQ-017 While reset=0 at a clk edge, the following SHALL clear:
- x_o=0, dv_out=0, out_index=0, frame_start=0, overrun=0;
- x_prev=0, pending=0, write pointer=0, counter=0;
- state=FILL.
REQ-018 Reset asserted mid-emission SHALL drop dv_out the cycle after the edge and discard the partial frame; RAM contents need not clear.
REQ-019 A write coincident with active reset SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Constant input: after reset, 256 writes of x_i=1000 with rdy_i=1 -> one frame, out_index 0..255, x_o[0]=1000, x_o[1..255]=31, frame_start only at index 0.
- Saturation: write -32768 then 32767 -> stored y=32767; write 32767 then -32768 -> stored y=-32768.
- Hop: 384 writes of ramp x_i=n -> second frame emitted after write 384, containing the pre-emphasized samples 128..383.
- Backpressure: rdy_i=0 from index 10 for 50 cycles -> x_o and out_index held; resumes at index 10 with no gaps or repeats.
- Overrun: rdy_i=0 throughout, 512 writes -> first frame stalled, second frame pending, third frame due -> overrun=1, pending base unchanged.
- Reset mid-frame: reset=0 at index 100 -> dv_out=0 next cycle, state FILL, 256 more writes needed before the next frame.
